// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/grant types and default latency for mem_access_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {GNT_IF, GNT_DM} grant_t;
    localparam int MEM_LATENCY_DEF = 1;
endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: combinational winner select between fetch and data ports.
// MEM_ARB_ROUND_ROBIN_EN alternates ties via last_grant; otherwise the data port always wins.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_grant,
    output logic grant
);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign grant = (if_req && dm_req) ? ((last_grant == GNT_DM) ? GNT_IF : GNT_DM)
                                      : (dm_req ? GNT_DM : GNT_IF);
`else
    logic unused_in;
    assign unused_in = if_req ^ last_grant;
    assign grant = dm_req ? GNT_DM : GNT_IF;
`endif
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares the single-port data memory between instruction fetch and the data stage.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests (default: data port wins).
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sel_dm;
    logic             lat_we;
    logic             grant;
    logic             last_grant;
`ifndef MEM_ARB_ROUND_ROBIN_EN
    assign last_grant = GNT_IF;
`endif
    mem_arb_picker u_picker (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .last_grant (last_grant),
        .grant      (grant)
    );
    assign busy = (state != IDLE);
    // mem_addr/mem_wdata are the latches themselves, so they hold through IDLE and RESP
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_dm    <= 1'b0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= GNT_IF;
`endif
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: if (if_req || dm_req) begin
                    sel_dm    <= (grant == GNT_DM);
                    lat_we    <= (grant == GNT_DM) && dm_we;
                    mem_we    <= (grant == GNT_DM) && dm_we;
                    mem_addr  <= (grant == GNT_DM) ? dm_addr : if_addr;
                    mem_wdata <= (grant == GNT_DM) ? dm_wdata : mem_wdata;
                    cnt       <= CNT_W'(MEM_LATENCY - 1);
                    state     <= ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant <= grant;
`endif
                end
                ACCESS: if (cnt == '0) begin
                    if (!lat_we && sel_dm) dm_rdata <= mem_rdata;
                    if (!lat_we && !sel_dm) if_rdata <= mem_rdata;
                    if_ack <= !sel_dm;
                    dm_ack <= sel_dm;
                    state  <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // requester must hold its request until the ack has been seen
    a_req_held: assert property (@(posedge clock) disable iff (!reset_n)
        (state != IDLE) |-> (sel_dm ? dm_req : if_req));
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed checks of mem_access_arbiter at MEM_LATENCY 1 (dut_a) and 3 (dut_b)
module tb_mem_access_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_req, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic        if_ack, dm_ack, mem_we, busy;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        b_dm_req, b_dm_we;
    logic [15:0] b_dm_addr, b_dm_wdata;
    logic        b_if_ack, b_dm_ack, b_mem_we, b_busy;
    logic [15:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [15:0] mem_a [65536];
    logic [15:0] mem_b [65536];
    int vectors = 0;
    int miscompares = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam int TIE2_IF = 2;
    localparam int TIE2_DM = 5;
`else
    localparam int TIE2_IF = 5;
    localparam int TIE2_DM = 2;
`endif

    always #5 clock = ~clock;

    assign mem_rdata   = mem_a[mem_addr];
    assign b_mem_rdata = mem_b[b_mem_addr];
    always @(posedge clock) if (mem_we) mem_a[mem_addr] <= mem_wdata;
    always @(posedge clock) if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;

    mem_access_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_access_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(3)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .if_req(1'b0), .if_addr(16'h0000), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata),
        .busy(b_busy)
    );

    // single access on dut_a: returns ack cycle (1 = first ACCESS cycle) and mem_we-high cycles
    task automatic run_a(input logic dm, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, output int lat, output int wes);
        bit drop;
        lat = 0; wes = 0; drop = 0;
        @(posedge clock); #1;
        if (dm) begin dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wdata; end
        else begin if_req = 1; if_addr = addr; end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (drop) break;
            @(negedge clock);
            wes += int'(mem_we);
            if (dm ? dm_ack : if_ack) begin lat = i; drop = 1; end
        end
        dm_req = 0; if_req = 0;
    endtask

    task automatic tie(input logic [15:0] ia, input logic [15:0] da, output int t_if, output int t_dm);
        bit drop_if, drop_dm;
        t_if = 0; t_dm = 0; drop_if = 0; drop_dm = 0;
        @(posedge clock); #1;
        if_req = 1; if_addr = ia; dm_req = 1; dm_we = 0; dm_addr = da;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (drop_if) begin if_req = 0; drop_if = 0; end
            if (drop_dm) begin dm_req = 0; drop_dm = 0; end
            if (t_if != 0 && t_dm != 0) break;
            @(negedge clock);
            if (if_ack) begin t_if = i; drop_if = 1; end
            if (dm_ack) begin t_dm = i; drop_dm = 1; end
        end
        if_req = 0; dm_req = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
        b_dm_req = 0; b_dm_we = 0; b_dm_addr = 0; b_dm_wdata = 0;
        #12;
        vectors++; if ({if_ack, dm_ack, mem_we, busy} !== 4'b0) begin miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000", {if_ack, dm_ack, mem_we, busy}); end
        vectors++; if (mem_addr !== 16'h0) begin miscompares++;
            $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        vectors++; if (mem_wdata !== 16'h0) begin miscompares++;
            $display("FAIL reset_mem_wdata: got %h expected 0000", mem_wdata); end
        vectors++; if (if_rdata !== 16'h0) begin miscompares++;
            $display("FAIL reset_if_rdata: got %h expected 0000", if_rdata); end
        vectors++; if (dm_rdata !== 16'h0) begin miscompares++;
            $display("FAIL reset_dm_rdata: got %h expected 0000", dm_rdata); end
        vectors++; if ({b_busy, b_dm_ack, b_mem_we} !== 3'b0) begin miscompares++;
            $display("FAIL reset_b_ctrl: got %b expected 000", {b_busy, b_dm_ack, b_mem_we}); end
        @(negedge clock); reset_n = 1;
    endtask

    task automatic test_fetch();
        int lat, wes;
        run_a(1'b0, 1'b0, 16'h0010, 16'h0, lat, wes);
        vectors++; if (lat !== 2) begin miscompares++;
            $display("FAIL fetch_latency: got %0d expected 2", lat); end
        vectors++; if (if_rdata !== 16'hBEEF) begin miscompares++;
            $display("FAIL fetch_rdata: got %h expected beef", if_rdata); end
        vectors++; if (wes !== 0) begin miscompares++;
            $display("FAIL fetch_mem_we: got %0d expected 0", wes); end
        vectors++; if (mem_addr !== 16'h0010) begin miscompares++;
            $display("FAIL fetch_addr_hold: got %h expected 0010", mem_addr); end
    endtask

    task automatic test_store();
        int lat, wes;
        run_a(1'b1, 1'b1, 16'h0042, 16'h1234, lat, wes);
        vectors++; if (lat !== 2) begin miscompares++;
            $display("FAIL store_latency: got %0d expected 2", lat); end
        vectors++; if (wes !== 1) begin miscompares++;
            $display("FAIL store_we_cycles: got %0d expected 1", wes); end
        vectors++; if (dm_rdata !== 16'h0) begin miscompares++;
            $display("FAIL store_rdata_hold: got %h expected 0000", dm_rdata); end
        vectors++; if (mem_a[16'h0042] !== 16'h1234) begin miscompares++;
            $display("FAIL store_mem: got %h expected 1234", mem_a[16'h0042]); end
        run_a(1'b1, 1'b0, 16'h0042, 16'h0, lat, wes);
        vectors++; if (dm_rdata !== 16'h1234 || lat !== 2) begin miscompares++;
            $display("FAIL load_back: got %h lat %0d expected 1234 lat 2", dm_rdata, lat); end
    endtask

    task automatic test_tie();
        int t_if, t_dm, lat, wes;
        tie(16'h0010, 16'h0042, t_if, t_dm);
        vectors++; if (t_dm !== 2 || t_if !== 5) begin miscompares++;
            $display("FAIL tie1_order: got dm %0d if %0d expected dm 2 if 5", t_dm, t_if); end
        vectors++; if (if_rdata !== 16'hBEEF || dm_rdata !== 16'h1234) begin miscompares++;
            $display("FAIL tie1_data: got if %h dm %h expected beef 1234", if_rdata, dm_rdata); end
        run_a(1'b1, 1'b0, 16'h0016, 16'h0, lat, wes);
        vectors++; if (dm_rdata !== 16'hA016) begin miscompares++;
            $display("FAIL dm_single: got %h expected a016", dm_rdata); end
        tie(16'h0012, 16'h0014, t_if, t_dm);
        vectors++; if (t_dm !== TIE2_DM || t_if !== TIE2_IF) begin miscompares++;
            $display("FAIL tie2_order: got dm %0d if %0d expected dm %0d if %0d", t_dm, t_if, TIE2_DM, TIE2_IF); end
        vectors++; if (if_rdata !== 16'hA012 || dm_rdata !== 16'hA014) begin miscompares++;
            $display("FAIL tie2_data: got if %h dm %h expected a012 a014", if_rdata, dm_rdata); end
    endtask

    task automatic test_latency3();
        int t, busy_n;
        bit drop;
        t = 0; busy_n = 0; drop = 0;
        @(posedge clock); #1;
        b_dm_req = 1; b_dm_we = 0; b_dm_addr = 16'h0020;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clock); #1;
            if (drop) begin b_dm_req = 0; drop = 0; end
            @(negedge clock);
            if (i == 1) b_dm_addr = 16'h0030;
            busy_n += int'(b_busy);
            if (b_dm_ack) begin t = i; drop = 1; end
        end
        b_dm_req = 0;
        vectors++; if (t !== 4) begin miscompares++;
            $display("FAIL lat3_ack_cycle: got %0d expected 4", t); end
        vectors++; if (busy_n !== 4) begin miscompares++;
            $display("FAIL lat3_busy_cycles: got %0d expected 4", busy_n); end
        vectors++; if (b_dm_rdata !== 16'hC0DE) begin miscompares++;
            $display("FAIL lat3_rdata: got %h expected c0de", b_dm_rdata); end
        vectors++; if (b_mem_addr !== 16'h0020) begin miscompares++;
            $display("FAIL lat3_addr_latched: got %h expected 0020", b_mem_addr); end
        vectors++; if (b_if_ack !== 1'b0 || b_if_rdata !== 16'h0) begin miscompares++;
            $display("FAIL lat3_if_idle: got %b %h expected 0 0000", b_if_ack, b_if_rdata); end
    endtask

    task automatic test_reset_mid_write();
        int acks, lat, wes;
        bit drop;
        acks = 0; lat = 0; wes = 0; drop = 0;
        @(posedge clock); #1;
        dm_req = 1; dm_we = 1; dm_addr = 16'h0050; dm_wdata = 16'h5555;
        @(posedge clock); #1;
        vectors++; if (mem_we !== 1'b1) begin miscompares++;
            $display("FAIL rst_pre_we: got %b expected 1", mem_we); end
        reset_n = 0;
        #1;
        vectors++; if (mem_we !== 1'b0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL rst_async: got we %b busy %b expected 0 0", mem_we, busy); end
        for (int i = 0; i < 3; i++) begin @(negedge clock); acks += int'(dm_ack); end
        reset_n = 1;
        vectors++; if (acks !== 0) begin miscompares++;
            $display("FAIL rst_no_ack: got %0d expected 0", acks); end
        vectors++; if (mem_a[16'h0050] !== 16'hA050) begin miscompares++;
            $display("FAIL rst_no_write: got %h expected a050", mem_a[16'h0050]); end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (drop) break;
            @(negedge clock);
            wes += int'(mem_we);
            if (dm_ack) begin lat = i; drop = 1; end
        end
        dm_req = 0;
        vectors++; if (lat !== 2 || wes !== 1) begin miscompares++;
            $display("FAIL rst_reissue: got lat %0d we %0d expected 2 1", lat, wes); end
        vectors++; if (mem_a[16'h0050] !== 16'h5555) begin miscompares++;
            $display("FAIL rst_reissue_mem: got %h expected 5555", mem_a[16'h0050]); end
    endtask

    task automatic test_back_to_back();
        int t1, t2, hold_bad;
        logic [15:0] v1, v2;
        bit nxt;
        t1 = 0; t2 = 0; hold_bad = 0; v1 = 0; v2 = 0; nxt = 0;
        @(posedge clock); #1;
        dm_req = 1; dm_we = 0; dm_addr = 16'h0010;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (nxt) begin dm_addr = 16'h0042; nxt = 0; end
            @(negedge clock);
            if (dm_ack && t1 == 0) begin t1 = i; v1 = dm_rdata; nxt = 1; end
            else if (dm_ack) begin t2 = i; v2 = dm_rdata; break; end
            else if (t1 != 0 && dm_rdata !== 16'hBEEF) hold_bad++;
        end
        @(posedge clock); #1;
        dm_req = 0;
        vectors++; if (t1 !== 2 || t2 - t1 !== 3) begin miscompares++;
            $display("FAIL b2b_spacing: got t1 %0d t2 %0d expected 2 5", t1, t2); end
        vectors++; if (v1 !== 16'hBEEF) begin miscompares++;
            $display("FAIL b2b_first: got %h expected beef", v1); end
        vectors++; if (v2 !== 16'h1234) begin miscompares++;
            $display("FAIL b2b_second: got %h expected 1234", v2); end
        vectors++; if (hold_bad !== 0) begin miscompares++;
            $display("FAIL b2b_hold: got %0d bad cycles expected 0", hold_bad); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem_a[i] = 16'hA000 | 16'(i & 255);
            mem_b[i] = 16'hB000 | 16'(i & 255);
        end
        mem_a[16'h0010] = 16'hBEEF;
        mem_b[16'h0020] = 16'hC0DE;
        mem_b[16'h0030] = 16'hDEAD;
        test_reset();
        test_fetch();
        test_store();
        test_tie();
        test_latency3();
        test_reset_mid_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
